// File: rtl/panel_run_ctrl.sv
// Front-panel run/halt/step sequencer: debounces the panel switches into
// one-cycle press events and sequences the CPU clock-enable and clear pulse.
module panel_run_ctrl #(
  parameter int DEB_CYCLES = 8
) (
  input  logic SYSCLK,
  input  logic RESET,
  input  logic sw_CLEAR,
  input  logic sw_RUN,
  input  logic sw_HALT,
  input  logic sw_STEPM,
  input  logic sw_STEPI,
  input  logic cycleDone,
  input  logic instDone,
  input  logic cpuHalt,
  output logic cpuRun,
  output logic cpuClear,
  output logic ledRun
);

  // state  | meaning
  // HALTED | CPU stopped, waiting for a panel event
  // CLR    | one-cycle CPU clear pulse
  // RUN    | free running
  // DRAIN  | halt requested, finishing the current instruction
  // STEPM  | executing a single major cycle
  // STEPI  | executing a single instruction
  typedef enum logic [2:0] {HALTED, CLR, RUN, DRAIN, STEPM, STEPI} state_t;

  localparam int SW_CLEAR = 0;
  localparam int SW_HALT  = 1;
  localparam int SW_RUN   = 2;
  localparam int SW_STEPI = 3;
  localparam int SW_STEPM = 4;
  localparam logic [7:0] CNT_LAST = 8'(DEB_CYCLES - 1);

  logic [4:0] raw;
  logic [4:0] meta_q, meta_d;
  logic [4:0] sync_q, sync_d;
  logic [4:0] deb_q, deb_d;
  logic [4:0] deb_dly_q, deb_dly_d;
  logic [7:0] cnt_q [5];
  logic [7:0] cnt_d [5];
  logic [4:0] evt;
  state_t     state_q, state_d;
  logic       run_q, run_d;
  logic       clear_q, clear_d;

  assign raw = {sw_STEPM, sw_STEPI, sw_RUN, sw_HALT, sw_CLEAR};
  assign evt = deb_q & ~deb_dly_q;

  always_comb begin
    meta_d    = raw;
    sync_d    = meta_q;
    deb_dly_d = deb_q;
    deb_d     = deb_q;
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = 8'd0;
      if (sync_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) deb_d[i] = sync_q[i];
        else                      cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  // Done/halt inputs only matter in states where the CPU clock is enabled.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HALTED: begin
        if (evt[SW_CLEAR])      state_d = CLR;
        else if (!evt[SW_HALT]) begin
          if (evt[SW_RUN])        state_d = RUN;
          else if (evt[SW_STEPI]) state_d = STEPI;
          else if (evt[SW_STEPM]) state_d = STEPM;
        end
      end
      CLR: state_d = HALTED;
      RUN: begin
        if (evt[SW_CLEAR])                state_d = CLR;
        else if (evt[SW_HALT] || cpuHalt) state_d = instDone ? HALTED : DRAIN;
      end
      DRAIN: begin
        if (evt[SW_CLEAR]) state_d = CLR;
        else if (instDone) state_d = HALTED;
      end
      STEPM: begin
        if (evt[SW_CLEAR])  state_d = CLR;
        else if (cycleDone) state_d = HALTED;
      end
      STEPI: begin
        if (evt[SW_CLEAR])             state_d = CLR;
        else if (instDone || cpuHalt)  state_d = HALTED;
        else if (evt[SW_HALT])         state_d = DRAIN;
      end
      default: state_d = HALTED;
    endcase
    run_d   = state_d inside {RUN, DRAIN, STEPM, STEPI};
    clear_d = (state_d == CLR);
  end

  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      meta_q    <= '0;
      sync_q    <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= 8'd0;
      state_q   <= HALTED;
      run_q     <= 1'b0;
      clear_q   <= 1'b0;
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
      state_q   <= state_d;
      run_q     <= run_d;
      clear_q   <= clear_d;
    end
  end

  assign cpuRun   = run_q;
  assign cpuClear = clear_q;
  assign ledRun   = run_q;

endmodule

// File: tb/tb_panel_run_ctrl.sv
// Self-checking bench for panel_run_ctrl with DEB_CYCLES = 4 (press reaches
// the FSM on the 7th edge after the raw switch rises).
module tb_panel_run_ctrl;

  logic SYSCLK = 1'b0;
  logic RESET;
  logic sw_CLEAR, sw_RUN, sw_HALT, sw_STEPM, sw_STEPI;
  logic cycleDone, instDone, cpuHalt;
  logic cpuRun, cpuClear, ledRun;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] exp_q [$];
  logic [2:0] got, e;

  panel_run_ctrl #(.DEB_CYCLES(4)) dut (
    .SYSCLK(SYSCLK), .RESET(RESET),
    .sw_CLEAR(sw_CLEAR), .sw_RUN(sw_RUN), .sw_HALT(sw_HALT),
    .sw_STEPM(sw_STEPM), .sw_STEPI(sw_STEPI),
    .cycleDone(cycleDone), .instDone(instDone), .cpuHalt(cpuHalt),
    .cpuRun(cpuRun), .cpuClear(cpuClear), .ledRun(ledRun)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic go_run();
    sw_RUN = 1'b1;
    idle(7);
    sw_RUN = 1'b0;
    idle(8);
  endtask

  // expected vector is {cpuRun, cpuClear, ledRun}
  task automatic test_reset();
    RESET = 1'b1;
    for (int c = 0; c < 3; c++) begin
      exp_q.push_back(3'b000);
      tick();
      got = {cpuRun, cpuClear, ledRun};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL reset c=%0d got=%b exp=%b", c, got, e);
      end
    end
    RESET = 1'b0;
  endtask

  task automatic test_debounce();
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < 10; c++) begin
        sw_RUN = (c < 3);
        exp_q.push_back(3'b000);
        tick();
        got = {cpuRun, cpuClear, ledRun};
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
          n_bad++;
          $display("FAIL glitch p=%0d c=%0d got=%b exp=%b", p, c, got, e);
        end
      end
    for (int c = 0; c < 10; c++) begin
      sw_RUN = 1'b1;
      exp_q.push_back((c + 1 >= 7) ? 3'b101 : 3'b000);
      tick();
      got = {cpuRun, cpuClear, ledRun};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL run_press c=%0d got=%b exp=%b", c, got, e);
      end
    end
    sw_RUN = 1'b0;
    idle(8);
  endtask

  task automatic test_halt_drain();
    for (int c = 0; c < 22; c++) begin
      sw_HALT  = (c < 14);
      instDone = (c == 11);
      exp_q.push_back((c + 1 < 12) ? 3'b101 : 3'b000);
      tick();
      got = {cpuRun, cpuClear, ledRun};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL halt_drain c=%0d got=%b exp=%b", c, got, e);
      end
    end
    instDone = 1'b0;
  endtask

  task automatic test_step();
    for (int c = 0; c < 13; c++) begin
      sw_STEPM  = 1'b1;
      cycleDone = (c == 9) || (c < 5);
      exp_q.push_back((c + 1 >= 7 && c + 1 < 10) ? 3'b101 : 3'b000);
      tick();
      got = {cpuRun, cpuClear, ledRun};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL stepm3 c=%0d got=%b exp=%b", c, got, e);
      end
    end
    sw_STEPM = 1'b0; cycleDone = 1'b0;
    idle(8);
    for (int c = 0; c < 17; c++) begin
      sw_STEPI = 1'b1;
      instDone = (c == 13);
      exp_q.push_back((c + 1 >= 7 && c + 1 < 14) ? 3'b101 : 3'b000);
      tick();
      got = {cpuRun, cpuClear, ledRun};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL stepi7 c=%0d got=%b exp=%b", c, got, e);
      end
    end
    sw_STEPI = 1'b0; instDone = 1'b0;
    idle(8);
    for (int c = 0; c < 10; c++) begin
      sw_STEPM  = 1'b1;
      cycleDone = 1'b1;
      exp_q.push_back((c + 1 == 7) ? 3'b101 : 3'b000);
      tick();
      got = {cpuRun, cpuClear, ledRun};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL stepm_done_early c=%0d got=%b exp=%b", c, got, e);
      end
    end
    sw_STEPM = 1'b0; cycleDone = 1'b0;
    idle(8);
  endtask

  task automatic test_clear_priority();
    go_run();
    for (int c = 0; c < 11; c++) begin
      sw_CLEAR = 1'b1;
      sw_HALT  = 1'b1;
      exp_q.push_back((c + 1 < 7) ? 3'b101 : (c + 1 == 7) ? 3'b010 : 3'b000);
      tick();
      got = {cpuRun, cpuClear, ledRun};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL clear_prio c=%0d got=%b exp=%b", c, got, e);
      end
    end
    sw_CLEAR = 1'b0; sw_HALT = 1'b0;
    idle(8);
  endtask

  task automatic test_cpu_halt();
    go_run();
    for (int c = 0; c < 9; c++) begin
      cpuHalt  = (c == 2) || (c > 4);
      instDone = (c == 2);
      exp_q.push_back((c + 1 < 3) ? 3'b101 : 3'b000);
      tick();
      got = {cpuRun, cpuClear, ledRun};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL cpu_halt_inst c=%0d got=%b exp=%b", c, got, e);
      end
    end
    cpuHalt = 1'b0; instDone = 1'b0;
    go_run();
    for (int c = 0; c < 6; c++) begin
      cpuHalt  = (c == 0);
      instDone = (c == 3);
      exp_q.push_back((c + 1 < 4) ? 3'b101 : 3'b000);
      tick();
      got = {cpuRun, cpuClear, ledRun};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL cpu_halt_drain c=%0d got=%b exp=%b", c, got, e);
      end
    end
    cpuHalt = 1'b0; instDone = 1'b0;
  endtask

  task automatic test_reset_mid();
    sw_STEPI = 1'b1;
    idle(7);
    exp_q.push_back(3'b101);
    RESET = 1'b1;
    exp_q.push_back(3'b000);
    e = exp_q.pop_front();
    got = {cpuRun, cpuClear, ledRun};
    n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL stepi_entry got=%b exp=%b", got, e);
    end
    tick();
    RESET = 1'b0;
    got = {cpuRun, cpuClear, ledRun};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL reset_mid got=%b exp=%b", got, e);
    end
    for (int c = 0; c < 14; c++) begin
      instDone = (c < 5) || (c == 9);
      exp_q.push_back((c + 1 >= 7 && c + 1 < 10) ? 3'b101 : 3'b000);
      tick();
      got = {cpuRun, cpuClear, ledRun};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL held_thru_reset c=%0d got=%b exp=%b", c, got, e);
      end
    end
    sw_STEPI = 1'b0; instDone = 1'b0;
    idle(8);
  endtask

  initial begin
    RESET = 1'b1;
    {sw_CLEAR, sw_RUN, sw_HALT, sw_STEPM, sw_STEPI} = '0;
    {cycleDone, instDone, cpuHalt} = '0;
    test_reset();
    test_debounce();
    test_halt_drain();
    test_step();
    test_clear_priority();
    test_cpu_halt();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
